// File: rtl/mp_add_pkg.sv
// Shared constants, FSM encoding and word-slice helper for mp_add_seq.
// Imported by the sequencer top.
package mp_add_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // LSB position of word idx inside a packed multi-word vector
    function automatic int unsigned word_lsb(input int unsigned idx);
        return idx * WORD_W;
    endfunction

endpackage

// File: rtl/cla_16bits.sv
// 16-bit carry-look-ahead adder built from four 4-bit look-ahead groups.
// Ports: x, y, c_in -> s, c_out.
module cla_16bits (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = c_in;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
        end
    end

    assign s     = p ^ c;
    assign c_out = gc[4];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit CLA reused per word, LSW first.
// Ports: clk, rst_n, in_* request (valid/ready), out_* result (valid/ready) + flags.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORDS*WORD_W-1:0]    in_a,
    input  logic [WORDS*WORD_W-1:0]    in_b,
    input  logic                       in_sub,
    input  logic [$clog2(WORDS)-1:0]   in_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDS*WORD_W-1:0]    out_sum,
    output logic                       out_cout,
    output logic                       out_ovf,
    output logic                       out_zero
);

    localparam int LW = $clog2(WORDS);
    localparam int W  = WORDS * WORD_W;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              sub_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     idx_q;
    logic              carry_q;
    logic              zero_acc_q;

    logic [WORD_W-1:0] a_w;
    logic [WORD_W-1:0] y_w;
    logic [WORD_W-1:0] s_w;
    logic              c_out;
    logic              accept;
    logic              last;
    logic              ovf_w;

    assign a_w = a_q[word_lsb(32'(idx_q)) +: WORD_W];
    // subtract is A + ~B + 1; the +1 comes from carry seeded with sub
    assign y_w = b_q[word_lsb(32'(idx_q)) +: WORD_W] ^ {WORD_W{sub_q}};

    assign ovf_w = (a_w[WORD_W-1] == y_w[WORD_W-1])
                 & (s_w[WORD_W-1] != a_w[WORD_W-1]);

    cla_16bits u_cla (
        .x     (a_w),
        .y     (y_w),
        .c_in  (carry_q),
        .s     (s_w),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        accept    = in_valid & in_ready;
        last      = (state_q == ST_RUN) && (idx_q == len_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            zero_acc_q <= 1'b0;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (accept) begin
            a_q        <= in_a;
            b_q        <= in_b;
            sub_q      <= in_sub;
            len_q      <= in_len;
            idx_q      <= '0;
            carry_q    <= in_sub;
            zero_acc_q <= 1'b1;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (state_q == ST_RUN) begin
            out_sum[word_lsb(32'(idx_q)) +: WORD_W] <= s_w;
            carry_q    <= c_out;
            zero_acc_q <= zero_acc_q & (s_w == '0);
            idx_q      <= idx_q + LW'(1);
            if (last) begin
                out_cout <= c_out;
                out_ovf  <= ovf_w;
                out_zero <= zero_acc_q & (s_w == '0);
            end
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4): random + directed ops
// against a wide-integer reference model.
module tb_mp_add_seq;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic [1:0]  in_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    always #5 clk = ~clk;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          sub;
        int          len;
        int          acc;
    } op_t;

    op_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndone = 0;
    int rdy_mode = 0;
    bit seen = 0;

    logic [63:0] last_sum;
    bit          last_co;
    bit          last_ov;
    bit          last_z;

    logic [63:0] m_s;
    bit          m_co;
    bit          m_ov;
    bit          m_z;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Reference: treat active words as one n-bit unsigned / signed number
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input bit sub, input int len,
                                  output logic [63:0] s, output bit co,
                                  output bit ov, output bit z);
        int n;
        logic [64:0] mask;
        logic [64:0] am;
        logic [64:0] bm;
        logic [64:0] full;
        logic signed [67:0] pw;
        logic signed [67:0] half;
        logic signed [67:0] sa;
        logic signed [67:0] sb;
        logic signed [67:0] r;
        n    = (len + 1) * 16;
        mask = (65'd1 << n) - 65'd1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        if (sub) begin
            full = (am - bm) & mask;
            co   = (am >= bm);
        end else begin
            full = am + bm;
            co   = full[n];
            full = full & mask;
        end
        s    = full[63:0];
        z    = (full == 65'd0);
        pw   = 68'sd1 <<< n;
        half = pw >>> 1;
        sa   = $signed({3'b000, am});
        sb   = $signed({3'b000, bm});
        if (sa >= half) sa = sa - pw;
        if (sb >= half) sb = sb - pw;
        r    = sub ? sa - sb : sa + sb;
        ov   = (r < -half) || (r >= half);
    endfunction

    // Single compare process: record accepts, check every valid cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            chk("busy_in_ready", in_ready, 0);
            if (q.size() == 0) begin
                fail_now("spurious_out_valid");
            end else begin
                model(q[0].a, q[0].b, q[0].sub, q[0].len, m_s, m_co, m_ov, m_z);
                if (!seen) chk("latency", cyc - q[0].acc, q[0].len + 1);
                seen = 1;
                chk("sum", out_sum, m_s);
                chk("cout", out_cout, m_co);
                chk("ovf", out_ovf, m_ov);
                chk("zero", out_zero, m_z);
                if (out_ready) begin
                    last_sum = out_sum;
                    last_co  = out_cout;
                    last_ov  = out_ovf;
                    last_z   = out_zero;
                    void'(q.pop_front());
                    seen = 0;
                    ndone++;
                end
            end
        end else if (in_valid && in_ready) begin
            q.push_back('{a: in_a, b: in_b, sub: in_sub,
                          len: int'(in_len), acc: cyc + 1});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic scramble();
        in_a   = {$urandom, $urandom};
        in_b   = {$urandom, $urandom};
        in_sub = 1'($urandom_range(0, 1));
        in_len = 2'($urandom_range(0, 3));
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input bit sub, input int len);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_len = 2'(len);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int nb);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (ndone > nb) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("result");
    endtask

    task automatic directed(input string name,
                            input logic [63:0] a, input logic [63:0] b,
                            input bit sub, input int len,
                            input logic [63:0] es, input bit eco,
                            input bit eov, input bit ez);
        int nb;
        nb = ndone;
        run_op(a, b, sub, len);
        wait_done(nb);
        chk({name, "_sum"}, last_sum, es);
        chk({name, "_cout"}, last_co, eco);
        chk({name, "_ovf"}, last_ov, eov);
        chk({name, "_zero"}, last_z, ez);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        bit ok;
        logic [63:0] ra;
        logic [63:0] rb;

        // pin the reference model with hand-computed values
        model(64'h0000_FFFF_FFFF_FFFF, 64'h1, 0, 3, m_s, m_co, m_ov, m_z);
        chk("model_chain", m_s, 64'h0001_0000_0000_0000);
        model(64'h8000_0000_0000_0000, 64'h1, 1, 3, m_s, m_co, m_ov, m_z);
        chk("model_subovf", {m_s[62:0], m_ov}, {63'h7FFF_FFFF_FFFF_FFFF, 1'b1});
        model(64'hDEAD_BEEF_CAFE_1234, 64'h1111_2222_3333_0001, 0, 0,
              m_s, m_co, m_ov, m_z);
        chk("model_len0", m_s, 64'h1235);

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_flags", {out_cout, out_ovf, out_zero}, 0);
        #20;
        rst_n = 1'b1;

        directed("chain", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 0, 3,
                 64'h0001_0000_0000_0000, 0, 0, 0);
        directed("borrow", 64'h0, 64'h1, 1, 3,
                 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        directed("sub53", 64'h5, 64'h3, 1, 3, 64'h2, 1, 0, 0);
        directed("addovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 3,
                 64'h8000_0000_0000_0000, 0, 1, 0);
        directed("subovf", 64'h8000_0000_0000_0000, 64'h1, 1, 3,
                 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
        directed("wrap0", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 3,
                 64'h0, 1, 0, 1);
        directed("len0", 64'hDEAD_BEEF_CAFE_1234, 64'h1111_2222_3333_0001, 0, 0,
                 64'h1235, 0, 0, 0);
        directed("len0ovf", 64'hDEAD_BEEF_CAFE_7FFF, 64'h1111_2222_3333_0001, 0, 0,
                 64'h8000, 0, 1, 0);

        // backpressure: hold result, hammer in_valid with junk
        rdy_mode = 2;
        nb = ndone;
        run_op(64'h0000_FFFF_FFFF_FFFF, 64'h1, 0, 3);
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("hold_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            scramble();
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        wait_done(nb);
        chk("hold_sum", last_sum, 64'h0001_0000_0000_0000);

        // reset in the middle of RUN
        run_op(64'h0000_FFFF_FFFF_FFFF, 64'h1, 0, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_sum", out_sum, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        directed("after_rst", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 0, 3,
                 64'h0001_0000_0000_0000, 0, 0, 0);

        // randomized operations with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       ra = 64'h8000_8000_8000_8000;
                2:       ra = 64'h0;
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 64'h1;
                default: rb = {$urandom, $urandom};
            endcase
            nb = ndone;
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            wait_done(nb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rdy_mode = 0;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
